axi_stream_real_source: RTL
===========================

# axi_stream_real_source

AXI-Stream transmitter that buffers a frame of IEEE-754 double words written by a local controller and sends it as one packet, with TLAST on the final beat. It is the master-side counterpart to the cubic evaluation stages and drives the first stage's slave port (TDATA = `$realtobits` of a real value). It honours backpressure without bubbles, so the downstream pipeline sees full-throughput, protocol-clean traffic.

## Interface
Parameters:
- DEPTH, 8, maximum words per frame; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- wr_en  in  1  write one word into the frame buffer
- wr_data  in  64  word to write (double bits)
- start  in  1  send the buffered frame
- busy  out  1  frame transmission in progress
- frame_done  out  1  one-cycle pulse after the last beat handshakes
- wr_drop  out  1  one-cycle pulse when a write is rejected
- nexti  in  axi_stream_masteri_slaveo_t  TREADY from the downstream slave
- nexto  out  axi_stream_mastero_slavei_t  TVALID, TDATA[63:0], TLAST to the downstream slave

## Operation
- States: FILL, SEND.
- Reset values (applied immediately while rst=0): state FILL; count 0; rd_ptr 0; TVALID, TLAST, busy, frame_done, wr_drop at 0; TDATA 0. Buffer contents are not reset.
- FILL:
  - wr_en with count<DEPTH: buf[count] ← wr_data, count+1.
  - wr_en with count==DEPTH: word dropped, wr_drop pulses.
  - start is evaluated against the post-write count; a simultaneous wr_en word belongs to the frame.
  - start with a post-write count of 0 is ignored.
  - Otherwise: go to SEND with rd_ptr=0.
- SEND:
  - TVALID=1, TDATA=buf[rd_ptr], TLAST=(rd_ptr==count-1).
  - Handshake is TVALID && TREADY. On a non-last handshake, rd_ptr+1.
  - On the last handshake: next state FILL, count←0, rd_ptr←0, frame_done pulses.
  - wr_en is dropped with a wr_drop pulse. start is ignored.
- AXI rules: once TVALID is high it stays high until handshake. TDATA and TLAST are stable while TVALID && !TREADY. TLAST never rises without TVALID. TVALID does not wait on TREADY.
- Pointer and count widths are $clog2(DEPTH+1). No wrap-around: count saturates at DEPTH by rejection.

## Timing
- All outputs are registered.
- start sampled at edge T (count>0) → beat 0 valid and busy=1 from T+1.
- With TREADY held high, an N-word frame occupies T+1..T+N, one beat per cycle, TLAST at T+N.
- At T+N+1: TVALID=0, busy=0, frame_done=1, and writes are accepted.
- Each low-TREADY cycle on a beat extends the frame by one cycle. There are no idle cycles between beats.
- wr_drop is asserted the cycle after the rejected write edge.
- Reset mid-frame: outputs drop asynchronously and the frame is discarded. After reset is released, the block idles in FILL with an empty buffer.

## Configuration
- AXIS_SRC_PROTOCOL_CHECK_EN defined: simulation-only checks on the nexto/nexti pair, each failure reporting `$error` then `$finish`:
  - TVALID fell without a handshake.
  - TDATA or TLAST changed during backpressure.
  - TLAST asserted without TVALID.
  - Backpressure lasted more than 100 consecutive cycles.
- Undefined: no checker logic, identical functional behaviour.

## Structure
- Shared package:
  - The AXI-Stream structs (already shared, reused unchanged).
  - DATA_W=64.
  - The state_t enum {FILL, SEND}.
- Sub-module axi_stream_frame_buf: DEPTH×64 register file, synchronous write, combinational read by rd_ptr. The top level holds the FSM, counters and output registers.

## Test plan
- Write 1.0, 2.0, 3.0; start; TREADY=1 → TDATA 1.0, 2.0, 3.0 on consecutive cycles, TLAST only with 3.0, one frame_done pulse at T+4.
- Same frame, TREADY low for 5 cycles while 2.0 is presented → TVALID stays 1, TDATA=2.0 and TLAST=0 held, frame finishes at T+9.
- Write -0.5; start → single beat with TLAST=1, busy high for 1 cycle.
- DEPTH=8: write 9 words → wr_drop on the 9th, frame carries 8 beats. Start with an empty buffer → TVALID stays 0. wr_en during SEND → wr_drop, frame unchanged.
- Two words buffered, then start and wr_en(7.0) in the same cycle → 3-beat frame ending in 7.0 with TLAST.
- rst low after the first handshake of a 4-word frame → TVALID, TLAST and busy are 0 before the next edge. After release, start alone → no TVALID.

Source files
------------

// File: rtl/axi_stream_real_source_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_real_source_pkg
// Description : Shared AXI-Stream structs, data width and FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_stream_real_source_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic tready;
    } axi_stream_masteri_slaveo_t;

    typedef struct packed {
        logic              tvalid;
        logic [DATA_W-1:0] tdata;
        logic              tlast;
    } axi_stream_mastero_slavei_t;

endpackage
`default_nettype wire

// File: rtl/axi_stream_real_source_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_real_source_if
// Description : AXI-Stream link between a master and a downstream slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_stream_real_source_if;
    import axi_stream_real_source_pkg::*;

    axi_stream_masteri_slaveo_t nexti;
    axi_stream_mastero_slavei_t nexto;

    modport master (input nexti, output nexto);
    modport slave  (input nexto, output nexti);

endinterface
`default_nettype wire

// File: rtl/axi_stream_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_frame_buf
// Description : DEPTH x DATA_W register file, synchronous write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_frame_buf
    import axi_stream_real_source_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  wire logic                           clk,
    input  wire logic                           i_we,
    input  wire logic [$clog2(DEPTH+1)-1:0]     i_waddr,
    input  wire logic [DATA_W-1:0]              i_wdata,
    input  wire logic [$clog2(DEPTH+1)-1:0]     i_raddr,
    output logic      [DATA_W-1:0]              o_rdata
);

    localparam int c_PTR_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i_we && (i_waddr == c_PTR_W'(i))) begin
                r_mem[i] <= i_wdata;
            end
        end
    end

    // Out-of-range addresses read as zero.
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_raddr == c_PTR_W'(i)) begin
                o_rdata = r_mem[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_stream_real_source.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_real_source
// Description : Buffers a frame of double words and sends it as one
//               AXI-Stream packet with TLAST on the final beat.
//               Optional macro AXIS_SRC_PROTOCOL_CHECK_EN adds sim checks.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_real_source
    import axi_stream_real_source_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  wr_en,
    input  wire logic [DATA_W-1:0]     wr_data,
    input  wire logic                  start,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       wr_drop,
    axi_stream_real_source_if.master   axis
);

    localparam int                   c_PTR_W = $clog2(DEPTH+1);
    localparam logic [c_PTR_W-1:0]   c_DEPTH = c_PTR_W'(DEPTH);
    localparam logic [c_PTR_W-1:0]   c_ONE   = c_PTR_W'(1);

    state_t              r_state;
    logic [c_PTR_W-1:0]  r_count;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic                r_tvalid;
    logic                r_tlast;
    logic [DATA_W-1:0]   r_tdata;
    logic                r_busy;
    logic                r_frame_done;
    logic                r_wr_drop;

    logic                w_wr_accept;
    logic                w_handshake;
    logic [c_PTR_W-1:0]  w_post_count;
    logic [c_PTR_W-1:0]  w_next_ptr;
    logic [c_PTR_W-1:0]  w_rd_addr;
    logic [DATA_W-1:0]   w_rd_data;
    logic [DATA_W-1:0]   w_first_word;

    assign w_wr_accept  = (r_state == FILL) && wr_en && (r_count < c_DEPTH);
    assign w_post_count = w_wr_accept ? (r_count + c_ONE) : r_count;
    assign w_handshake  = r_tvalid && axis.nexti.tready;
    assign w_next_ptr   = r_rd_ptr + c_ONE;
    // Look one beat ahead so the next TDATA can be registered on the handshake.
    assign w_rd_addr    = (r_state == SEND) ? w_next_ptr : '0;
    // A word written in the start cycle is not in the buffer yet.
    assign w_first_word = (w_wr_accept && (r_count == '0)) ? wr_data : w_rd_data;

    axi_stream_frame_buf #(
        .DEPTH   (DEPTH)
    ) u_frame_buf (
        .clk     (clk),
        .i_we    (w_wr_accept),
        .i_waddr (r_count),
        .i_wdata (wr_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= FILL;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_tdata      <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_wr_drop    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_wr_drop    <= 1'b0;
            case (r_state)
                FILL: begin
                    r_wr_drop <= wr_en && !w_wr_accept;
                    r_count   <= w_post_count;
                    if (start && (w_post_count != '0)) begin
                        r_state  <= SEND;
                        r_rd_ptr <= '0;
                        r_tvalid <= 1'b1;
                        r_tdata  <= w_first_word;
                        r_tlast  <= (w_post_count == c_ONE);
                        r_busy   <= 1'b1;
                    end
                end
                SEND: begin
                    r_wr_drop <= wr_en;
                    if (w_handshake) begin
                        if (r_tlast) begin
                            r_state      <= FILL;
                            r_count      <= '0;
                            r_rd_ptr     <= '0;
                            r_tvalid     <= 1'b0;
                            r_tlast      <= 1'b0;
                            r_tdata      <= '0;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_rd_ptr <= w_next_ptr;
                            r_tdata  <= w_rd_data;
                            r_tlast  <= (w_next_ptr == (r_count - c_ONE));
                        end
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign axis.nexto = '{tvalid: r_tvalid, tdata: r_tdata, tlast: r_tlast};
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign wr_drop    = r_wr_drop;

`ifdef AXIS_SRC_PROTOCOL_CHECK_EN
    logic              r_chk_stall;
    logic [DATA_W-1:0] r_chk_data;
    logic              r_chk_last;
    int unsigned       r_chk_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chk_stall     <= 1'b0;
            r_chk_data      <= '0;
            r_chk_last      <= 1'b0;
            r_chk_stall_cnt <= 0;
        end else begin
            r_chk_stall     <= axis.nexto.tvalid && !axis.nexti.tready;
            r_chk_data      <= axis.nexto.tdata;
            r_chk_last      <= axis.nexto.tlast;
            r_chk_stall_cnt <= (axis.nexto.tvalid && !axis.nexti.tready) ?
                               (r_chk_stall_cnt + 1) : 0;
            if (r_chk_stall && !axis.nexto.tvalid) begin
                $error("axis source: TVALID fell without a handshake");
                $finish;
            end
            if (r_chk_stall && ((axis.nexto.tdata != r_chk_data) ||
                                (axis.nexto.tlast != r_chk_last))) begin
                $error("axis source: TDATA/TLAST changed during backpressure");
                $finish;
            end
            if (axis.nexto.tlast && !axis.nexto.tvalid) begin
                $error("axis source: TLAST asserted without TVALID");
                $finish;
            end
            if (r_chk_stall_cnt > 100) begin
                $error("axis source: backpressure exceeded 100 cycles");
                $finish;
            end
        end
    end
`endif

endmodule
`default_nettype wire
